// File: rtl/fpga_board_ctrl.sv
// Board-level bring-up controller: sequences the core reset from PLL lock,
// stretches status pulses onto LEDs, blinks a heartbeat and counts done events.
module fpga_board_ctrl #(
  parameter int N_STATUS         = 2,
  parameter int STRETCH_CYCLES   = 5000000,
  parameter int STRETCH_WIDTH    = 23,
  parameter int LOCK_WAIT_CYCLES = 1024,
  parameter int LOCK_CNT_WIDTH   = 11,
  parameter int HB_HALF_PERIOD   = 25000000,
  parameter int HB_WIDTH         = 25,
  parameter int EVT_CNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     pll_locked,
  input  logic [N_STATUS-1:0]      status_in,
  output logic                     core_reset_n,
  output logic [1:0]               state,
  output logic [N_STATUS-1:0]      status_led,
  output logic                     heartbeat_led,
  output logic [EVT_CNT_WIDTH-1:0] done_count,
  output logic                     lock_lost
);

  // state        | meaning
  // ST_RESET     | just out of reset, leaves unconditionally
  // ST_WAIT_LOCK | waiting for synchronised PLL lock
  // ST_SETTLE    | lock seen, counting continuous locked cycles
  // ST_RUN       | core released from reset
  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [LOCK_CNT_WIDTH-1:0] LOCK_TC    = LOCK_CNT_WIDTH'(LOCK_WAIT_CYCLES - 1);
  localparam logic [STRETCH_WIDTH-1:0]  STRETCH_LD = STRETCH_WIDTH'(STRETCH_CYCLES);
  localparam logic [HB_WIDTH-1:0]       HB_TC      = HB_WIDTH'(HB_HALF_PERIOD - 1);

  state_t                     state_q, state_d;
  logic                       sync1_q, sync2_q;
  logic [LOCK_CNT_WIDTH-1:0]  lock_cnt_q, lock_cnt_d;
  logic                       lock_lost_q, lock_lost_d;
  logic                       core_reset_n_q;
  logic [STRETCH_WIDTH-1:0]   s_cnt_q [N_STATUS];
  logic [STRETCH_WIDTH-1:0]   s_cnt_d [N_STATUS];
  logic [N_STATUS-1:0]        led_q, led_d;
  logic                       done_prev_q, done_prev_d;
  logic [EVT_CNT_WIDTH-1:0]   done_cnt_q, done_cnt_d;
  logic [HB_WIDTH-1:0]        hb_cnt_q, hb_cnt_d;
  logic                       hb_q, hb_d;
  logic                       locked_s;
  logic                       in_run;
  logic                       run_next;

  assign locked_s = sync2_q;
  assign in_run   = (state_q == ST_RUN);
  assign run_next = (state_d == ST_RUN);

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = '0;
    lock_lost_d = lock_lost_q;
    unique case (state_q)
      ST_RESET: state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (locked_s) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Losing lock outranks the terminal count.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (lock_cnt_q == LOCK_TC) begin
          state_d = ST_RUN;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_CNT_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d     = ST_WAIT_LOCK;
          lock_lost_d = 1'b1;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_STATUS; i++) begin
      s_cnt_d[i] = '0;
      if (in_run) begin
        led_d[i] = status_in[i] | (s_cnt_q[i] != '0);
        if (status_in[i]) begin
          s_cnt_d[i] = STRETCH_LD;
        end else if (s_cnt_q[i] != '0) begin
          s_cnt_d[i] = s_cnt_q[i] - STRETCH_WIDTH'(1);
        end
      end
    end
  end

  // The edge-detect copy is held low outside RUN so a level present at entry counts.
  always_comb begin
    done_prev_d = in_run ? status_in[0] : 1'b0;
    done_cnt_d  = done_cnt_q;
    if (in_run && status_in[0] && !done_prev_q && (done_cnt_q != '1)) begin
      done_cnt_d = done_cnt_q + EVT_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    hb_cnt_d = '0;
    hb_d     = 1'b0;
    if (run_next && in_run) begin
      if (hb_cnt_q == HB_TC) begin
        hb_d = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + HB_WIDTH'(1);
        hb_d     = hb_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_RESET;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      lock_cnt_q     <= '0;
      lock_lost_q    <= 1'b0;
      core_reset_n_q <= 1'b0;
      led_q          <= '0;
      done_prev_q    <= 1'b0;
      done_cnt_q     <= '0;
      hb_cnt_q       <= '0;
      hb_q           <= 1'b0;
      for (int i = 0; i < N_STATUS; i++) s_cnt_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= pll_locked;
      sync2_q        <= sync1_q;
      lock_cnt_q     <= lock_cnt_d;
      lock_lost_q    <= lock_lost_d;
      core_reset_n_q <= run_next;
      led_q          <= led_d;
      done_prev_q    <= done_prev_d;
      done_cnt_q     <= done_cnt_d;
      hb_cnt_q       <= hb_cnt_d;
      hb_q           <= hb_d;
      for (int i = 0; i < N_STATUS; i++) s_cnt_q[i] <= s_cnt_d[i];
    end
  end

  assign core_reset_n  = core_reset_n_q;
  assign state         = state_q;
  assign status_led    = led_q;
  assign heartbeat_led = hb_q;
  assign done_count    = done_cnt_q;
  assign lock_lost     = lock_lost_q;

endmodule

// File: tb/tb_fpga_board_ctrl.sv
// Self-checking bench for fpga_board_ctrl: behavioural model compared every
// cycle, plus directed literal checks and a randomized soak.
module tb_fpga_board_ctrl;

  localparam int NS = 2;
  localparam int SC = 8;
  localparam int LW = 4;
  localparam int HB = 5;
  localparam int EW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic [NS-1:0] status_in = '0;
  logic          core_reset_n;
  logic [1:0]    state;
  logic [NS-1:0] status_led;
  logic          heartbeat_led;
  logic [EW-1:0] done_count;
  logic          lock_lost;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpga_board_ctrl #(
    .N_STATUS(NS), .STRETCH_CYCLES(SC), .STRETCH_WIDTH(4),
    .LOCK_WAIT_CYCLES(LW), .LOCK_CNT_WIDTH(3),
    .HB_HALF_PERIOD(HB), .HB_WIDTH(3), .EVT_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .status_in(status_in),
    .core_reset_n(core_reset_n), .state(state), .status_led(status_led),
    .heartbeat_led(heartbeat_led), .done_count(done_count), .lock_lost(lock_lost)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: lock history, mode number, cycles since last status hit.
  int            cyc = 0;
  bit            m_started = 0;
  bit            m_s1, m_s2;
  int            m_state, m_settle, m_age, m_done;
  bit            m_lost, m_crn, m_hb, m_prev0;
  bit [NS-1:0]   m_led;
  int            m_hit [NS];
  bit            m_hitv [NS];

  always @(posedge clk) begin
    int nxt;
    bit ls;
    cyc++;
    if (!reset_n) begin
      m_started = 1; m_s1 = 0; m_s2 = 0; m_state = 0; m_settle = 0;
      m_lost = 0; m_crn = 0; m_hb = 0; m_age = 0; m_done = 0; m_prev0 = 0;
      m_led = '0;
      for (int i = 0; i < NS; i++) m_hitv[i] = 0;
    end else begin
      ls = m_s2;
      if (m_state == 3) begin
        for (int i = 0; i < NS; i++) begin
          m_led[i] = status_in[i] || (m_hitv[i] && (cyc - m_hit[i] <= SC));
          if (status_in[i]) begin
            m_hit[i] = cyc;
            m_hitv[i] = 1;
          end
        end
        if (status_in[0] && !m_prev0 && m_done < (1 << EW) - 1) m_done++;
        m_prev0 = status_in[0];
      end else begin
        m_led = '0;
        m_prev0 = 0;
        for (int i = 0; i < NS; i++) m_hitv[i] = 0;
      end
      nxt = m_state;
      case (m_state)
        0: nxt = 1;
        1: if (ls) begin nxt = 2; m_settle = 0; end
        2: begin
          if (!ls) nxt = 1;
          else begin
            m_settle++;
            if (m_settle == LW) nxt = 3;
          end
        end
        default: if (!ls) begin nxt = 1; m_lost = 1; end
      endcase
      if (nxt == 3 && m_state == 3) m_age++;
      else m_age = 0;
      m_hb  = (nxt == 3) && ((m_age / HB) % 2 == 1);
      m_crn = (nxt == 3);
      m_state = nxt;
      m_s2 = m_s1;
      m_s1 = pll_locked;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("state", int'(state), m_state);
      check("core_reset_n", int'(core_reset_n), int'(m_crn));
      check("status_led", int'(status_led), int'(m_led));
      check("heartbeat_led", int'(heartbeat_led), int'(m_hb));
      check("done_count", int'(done_count), m_done);
      check("lock_lost", int'(lock_lost), int'(m_lost));
    end
  end

  task automatic stretch_run(input int second, output int hi);
    hi = 0;
    for (int j = 0; j < 25; j++) begin
      status_in = (j == 0 || j == second) ? 2'b10 : 2'b00;
      step();
      if (status_led[1]) hi++;
    end
  endtask

  initial begin
    int edges;
    int hi;

    // Bring-up with lock present from the start.
    reset_n = 1'b0; pll_locked = 1'b1; status_in = '0;
    repeat (3) step();
    check("reset_state", int'(state), 0);
    check("reset_outputs", int'({core_reset_n, status_led, heartbeat_led, done_count, lock_lost}), 0);
    reset_n = 1'b1;
    edges = 0;
    while (state != 2'd3 && edges < 20) begin step(); edges++; end
    check("bringup_latency", edges, 7);
    check("bringup_crn", int'(core_reset_n), 1);
    edges = 0;
    while (!heartbeat_led && edges < 20) begin step(); edges++; end
    check("hb_first_toggle", edges, HB);

    // Stretch: single pulse, then retrigger 4 cycles later.
    stretch_run(-1, hi);
    check("stretch_single", hi, 9);
    stretch_run(4, hi);
    check("stretch_retrigger", hi, 13);

    // Lock glitch in SETTLE after a fresh reset.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    edges = 0;
    while (state != 2'd2 && edges < 20) begin step(); edges++; end
    check("glitch_reach_settle", int'(state), 2);
    pll_locked = 1'b0;
    repeat (3) step();
    check("glitch_back_to_wait", int'(state), 1);
    pll_locked = 1'b1;
    edges = 0;
    while (state != 2'd3 && edges < 20) begin step(); edges++; end
    check("glitch_relock_latency", edges, 7);
    check("glitch_no_lock_lost", int'(lock_lost), 0);

    // Lock loss in RUN, a done pulse while waiting, then relock.
    pll_locked = 1'b0;
    repeat (4) step();
    check("loss_state", int'(state), 1);
    check("loss_sticky", int'(lock_lost), 1);
    check("loss_crn", int'(core_reset_n), 0);
    status_in = 2'b01;
    step();
    status_in = 2'b00;
    step();
    check("wait_pulse_ignored", int'(done_count), 0);
    pll_locked = 1'b1;
    edges = 0;
    while (state != 2'd3 && edges < 30) begin step(); edges++; end
    check("relock_run", int'(state), 3);
    check("relock_lost_kept", int'(lock_lost), 1);

    // Done counter saturation with ten pulses.
    for (int j = 0; j < 20; j++) begin
      status_in = (j % 2 == 0) ? 2'b01 : 2'b00;
      step();
    end
    status_in = 2'b00;
    step();
    check("done_saturate", int'(done_count), 7);

    // Reset in the middle of a stretch.
    status_in = 2'b10;
    step();
    status_in = 2'b00;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    check("midreset_led", int'(status_led), 0);
    check("midreset_done", int'(done_count), 0);
    check("midreset_state", int'(state), 0);
    check("midreset_crn_hb", int'({core_reset_n, heartbeat_led, lock_lost}), 0);
    reset_n = 1'b1;

    // Randomized soak.
    for (int k = 0; k < 4000; k++) begin
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 999) < 3) reset_n = 1'b0;
      if (pll_locked) begin
        if ($urandom_range(0, 99) < 2) pll_locked = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 25) pll_locked = 1'b1;
      end
      for (int i = 0; i < NS; i++) status_in[i] = ($urandom_range(0, 99) < 12);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpga_board_ctrl.md
Name: fpga_board_ctrl

Overview:
- Board-level control block for FPGA bring-up of the accelerator core.
- Sequences the core reset from the PLL lock signal and holds the core in reset until lock has been stable for a programmable time.
- Stretches N_STATUS single-cycle status pulses (done_int, data_valid, ...) into visible LED pulses, drives a heartbeat LED, and counts done events.
- Sits between the PLL and top_design inside the FPGA wrapper; runs on the PLL output clock.

Parameters:
- N_STATUS, 2, number of status inputs/LED channels (bit 0 is the counted "done" channel)
- STRETCH_CYCLES, 5000000, LED hold time in clk cycles after a status bit falls (>=1)
- STRETCH_WIDTH, 23, counter width; must satisfy 2^STRETCH_WIDTH > STRETCH_CYCLES
- LOCK_WAIT_CYCLES, 1024, cycles of continuous lock required before releasing core reset (>=1)
- LOCK_CNT_WIDTH, 11, must satisfy 2^LOCK_CNT_WIDTH > LOCK_WAIT_CYCLES
- HB_HALF_PERIOD, 25000000, heartbeat toggle interval in cycles (>=1)
- HB_WIDTH, 25, heartbeat counter width
- EVT_CNT_WIDTH, 16, done event counter width

Ports:
- clk, input, 1, PLL output clock; sole clock
- reset_n, input, 1, synchronous active-low reset
- pll_locked, input, 1, PLL lock; asynchronous, synchronised internally
- status_in, input, N_STATUS, status bits from the core; synchronous to clk
- core_reset_n, output, 1, registered active-low reset to top_design
- state, output, 2, FSM state: 0 RESET, 1 WAIT_LOCK, 2 SETTLE, 3 RUN
- status_led, output, N_STATUS, stretched status LEDs
- heartbeat_led, output, 1, blinks while in RUN
- done_count, output, EVT_CNT_WIDTH, saturating count of status_in[0] rising edges
- lock_lost, output, 1, sticky: lock dropped while in RUN

Behaviour:
- Reset:
  - While reset_n=0 at a clk edge, all registers clear: state=RESET, core_reset_n=0, status_led=0, heartbeat_led=0, done_count=0, lock_lost=0.
  - Both lock synchroniser flops clear to 0, and all counters clear.
  - reset_n asserted mid-operation behaves identically; it takes priority over every other event.
- Lock sync: two-flop synchroniser gives locked_s, 2-cycle latency.
- FSM, one transition per clk:
  - RESET -> WAIT_LOCK unconditionally on the next cycle.
  - WAIT_LOCK: lock counter held at 0; locked_s=1 -> SETTLE.
  - SETTLE: counter increments each cycle. locked_s=0 -> WAIT_LOCK with counter cleared. Counter==LOCK_WAIT_CYCLES-1 with locked_s=1 -> RUN. The lock-drop check has priority over the terminal count.
  - RUN: locked_s=0 -> WAIT_LOCK and lock_lost<=1; lock_lost stays set until reset_n.
- core_reset_n is a register equal to (next state==RUN). It goes 1 in the same edge the state becomes RUN and 0 in the same edge RUN is exited.
- Status stretch, per channel i, active only in RUN:
  - Counter s_cnt[i] loads STRETCH_CYCLES on every cycle status_in[i]=1, otherwise decrements toward 0, saturating at 0.
  - status_led[i] is registered: 1 iff status_in[i]=1 or s_cnt[i]!=0 in the previous cycle.
  - Result: the LED rises 1 cycle after status_in[i] rises and falls exactly STRETCH_CYCLES+1 cycles after status_in[i] falls.
  - A retrigger during the hold restarts the hold.
  - Outside RUN, status_in is ignored, and s_cnt and status_led are forced to 0 next cycle.
- done_count:
  - Edge detect uses a registered copy of status_in[0]; the copy is cleared outside RUN, so a level already high on RUN entry counts as an edge.
  - Increments by 1 on each rising edge seen in RUN and saturates at all-ones.
  - Not cleared on lock loss; cleared only by reset_n.
- Heartbeat:
  - In RUN, a counter counts 0..HB_HALF_PERIOD-1 and wraps; heartbeat_led toggles on the wrap cycle.
  - The first toggle (0->1) occurs HB_HALF_PERIOD cycles after RUN entry.
  - Outside RUN, the counter and heartbeat_led are 0.
- No combinational paths from inputs to outputs.

Test Plan:
Use LOCK_WAIT_CYCLES=4, STRETCH_CYCLES=8, HB_HALF_PERIOD=5, EVT_CNT_WIDTH=3 unless stated.
1. Basic bring-up: reset_n=0 for 3 cycles, then 1; pll_locked=1 from cycle 0 -> state 0->1, 1 cycle later; SETTLE 2 cycles after locked_s rises; RUN and core_reset_n=1 4 cycles later. All outputs 0 during reset.
2. Lock glitch in SETTLE: pll_locked drops for 3 cycles after 2 settle cycles -> state returns to 1, counter restarts; a full 4 locked cycles are needed again; lock_lost stays 0.
3. Lock loss in RUN: drop pll_locked -> core_reset_n=0 on the same edge state leaves RUN (2 cycles after the drop plus 1); lock_lost=1. Re-lock reaches RUN again with lock_lost still 1.
4. Stretch: 1-cycle pulse on status_in[1] -> status_led[1] high for exactly 9 cycles starting 1 cycle later. A second pulse 4 cycles after the first extends the LED to 9 cycles past the second pulse.
5. Done counter: 10 single-cycle pulses on status_in[0] spaced 2 cycles apart -> done_count 1..7, then held at 7. A pulse while in WAIT_LOCK is not counted.
6. Heartbeat and mid-operation reset: in RUN, heartbeat_led toggles every 5 cycles. Assert reset_n=0 mid-stretch -> all outputs 0 at the next edge and done_count=0.
